// File: rtl/vga_timing_pkg.sv
// Shared phase encoding and default 640x480@60 raster timing for the VGA timing controller.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'b00,
        PH_BACK   = 2'b01,
        PH_ACTIVE = 2'b10,
        PH_FRONT  = 2'b11
    } phase_e;

    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;

    localparam int unsigned H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

    // Phase implied by a counter value, given the first count of BACK, ACTIVE and FRONT.
    function automatic phase_e phase_of(input logic [9:0] count, input logic [9:0] back_start,
                                        input logic [9:0] active_start,
                                        input logic [9:0] front_start);
        if (count < back_start) begin
            return PH_SYNC;
        end else if (count < active_start) begin
            return PH_BACK;
        end else if (count < front_start) begin
            return PH_ACTIVE;
        end
        return PH_FRONT;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_axis_seq.sv
// One raster axis: wrapping position counter plus SYNC/BACK/ACTIVE/FRONT phase FSM.
module vga_axis_seq
    import vga_timing_pkg::*;
#(
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       clear,
    output logic [9:0] count,
    output logic [1:0] phase,
    output logic       wrap
);

    localparam logic [9:0] BACK_START   = 10'(SYNC);
    localparam logic [9:0] ACTIVE_START = 10'(SYNC + BP);
    localparam logic [9:0] FRONT_START  = 10'(SYNC + BP + ACTIVE);
    localparam logic [9:0] LAST         = 10'(SYNC + BP + ACTIVE + FP - 1);

    logic [9:0] count_q;
    logic [9:0] count_d;
    phase_e     phase_q;

    assign wrap    = step & (count_q == LAST);
    assign count_d = wrap ? '0 : count_q + 10'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= PH_SYNC;
        end else if (clear) begin
            count_q <= '0;
            phase_q <= PH_SYNC;
        end else if (step) begin
            count_q <= count_d;
            // A phase that has drifted from its counter range is resynchronised on this step.
            if (phase_q != phase_of(count_q, BACK_START, ACTIVE_START, FRONT_START)) begin
                phase_q <= phase_of(count_d, BACK_START, ACTIVE_START, FRONT_START);
            end else begin
                unique case (phase_q)
                    PH_SYNC:   if (count_d == BACK_START)   phase_q <= PH_BACK;
                    PH_BACK:   if (count_d == ACTIVE_START) phase_q <= PH_ACTIVE;
                    PH_ACTIVE: if (count_d == FRONT_START)  phase_q <= PH_FRONT;
                    PH_FRONT:  if (wrap)                    phase_q <= PH_SYNC;
                endcase
            end
        end
    end

    assign count = count_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel-rate divider, H/V axis sequencers, sync and active-window decode.
// Define VGA_OUT_REG_EN to add one aligned output register stage on every output.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pixel_tick,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hsync,
    output logic       vsync,
    output logic       on_h,
    output logic       on_v,
    output logic       video_on,
    output logic [1:0] h_phase,
    output logic [1:0] v_phase,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned     DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic [1:0]       h_ph;
    logic [1:0]       v_ph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (enable) begin
            div_q <= (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        end
    end

    // Gated by reset so the tick is already low while reset is held with enable high.
    assign tick = enable & ~reset & (div_q == DIV_MAX);

    vga_axis_seq #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h_axis (
        .clk   (clk),
        .reset (reset),
        .step  (tick),
        .clear (1'b0),
        .count (h_count),
        .phase (h_ph),
        .wrap  (h_wrap)
    );

    vga_axis_seq #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v_axis (
        .clk   (clk),
        .reset (reset),
        .step  (h_wrap),
        .clear (1'b0),
        .count (v_count),
        .phase (v_ph),
        .wrap  (v_wrap)
    );

    logic hsync_c;
    logic vsync_c;
    logic on_h_c;
    logic on_v_c;

    assign hsync_c = (h_ph != PH_SYNC);
    assign vsync_c = (v_ph != PH_SYNC);
    assign on_h_c  = (h_ph == PH_ACTIVE);
    assign on_v_c  = (v_ph == PH_ACTIVE);

`ifdef VGA_OUT_REG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_tick  <= 1'b0;
            hCount      <= '0;
            vCount      <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            on_h        <= 1'b0;
            on_v        <= 1'b0;
            video_on    <= 1'b0;
            h_phase     <= PH_SYNC;
            v_phase     <= PH_SYNC;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_tick  <= tick;
            hCount      <= h_count;
            vCount      <= v_count;
            hsync       <= hsync_c;
            vsync       <= vsync_c;
            on_h        <= on_h_c;
            on_v        <= on_v_c;
            video_on    <= on_h_c & on_v_c;
            h_phase     <= h_ph;
            v_phase     <= v_ph;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end
`else
    assign pixel_tick  = tick;
    assign hCount      = h_count;
    assign vCount      = v_count;
    assign hsync       = hsync_c;
    assign vsync       = vsync_c;
    assign on_h        = on_h_c;
    assign on_v        = on_v_c;
    assign video_on    = on_h_c & on_v_c;
    assign h_phase     = h_ph;
    assign v_phase     = v_ph;
    assign line_start  = h_wrap;
    assign frame_start = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default-timing instance plus a tiny-raster instance, both checked
// every cycle against a position-arithmetic model, with a table of hand-derived raster points.
module tb_vga_timing_ctrl;

    localparam int unsigned S_CD = 1;
    localparam int unsigned S_HS = 5, S_HB = 4, S_HA = 10, S_HF = 3;
    localparam int unsigned S_VS = 2, S_VB = 3, S_VA = 6, S_VF = 2;
    localparam int unsigned S_HT = S_HS + S_HB + S_HA + S_HF;
    localparam int unsigned S_VT = S_VS + S_VB + S_VA + S_VF;
`ifdef VGA_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic       tick, ls, fs, hs, vs, onh, onv, vid;
        logic [1:0] hp, vp;
        logic [9:0] h, v;
    } outs_t;

    typedef struct {
        string           name;
        longint unsigned e;
        int unsigned     h, v;
        logic            tick, ls, hs, vs, vid;
        logic [1:0]      hp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;

    logic       d_tick, d_hs, d_vs, d_onh, d_onv, d_vid, d_ls, d_fs;
    logic [9:0] d_h, d_v;
    logic [1:0] d_hp, d_vp;
    logic       s_tick, s_hs, s_vs, s_onh, s_onv, s_vid, s_ls, s_fs;
    logic [9:0] s_h, s_v;
    logic [1:0] s_hp, s_vp;
    outs_t      act_d, act_s;

    int              checks = 0;
    int              errors = 0;
    longint unsigned e = 0;
    outs_t           prev_d = '0;
    outs_t           prev_s = '0;

    always #5 clk = ~clk;

    vga_timing_ctrl dut (
        .clk (clk), .reset (reset), .enable (enable),
        .pixel_tick (d_tick), .hCount (d_h), .vCount (d_v),
        .hsync (d_hs), .vsync (d_vs), .on_h (d_onh), .on_v (d_onv), .video_on (d_vid),
        .h_phase (d_hp), .v_phase (d_vp), .line_start (d_ls), .frame_start (d_fs)
    );

    vga_timing_ctrl #(
        .CLK_DIV (S_CD), .H_SYNC (S_HS), .H_BP (S_HB), .H_ACTIVE (S_HA), .H_FP (S_HF),
        .V_SYNC (S_VS), .V_BP (S_VB), .V_ACTIVE (S_VA), .V_FP (S_VF)
    ) dut_s (
        .clk (clk), .reset (reset), .enable (enable),
        .pixel_tick (s_tick), .hCount (s_h), .vCount (s_v),
        .hsync (s_hs), .vsync (s_vs), .on_h (s_onh), .on_v (s_onv), .video_on (s_vid),
        .h_phase (s_hp), .v_phase (s_vp), .line_start (s_ls), .frame_start (s_fs)
    );

    assign act_d = '{d_tick, d_ls, d_fs, d_hs, d_vs, d_onh, d_onv, d_vid, d_hp, d_vp, d_h, d_v};
    assign act_s = '{s_tick, s_ls, s_fs, s_hs, s_vs, s_onh, s_onv, s_vid, s_hp, s_vp, s_h, s_v};

    // Position is simply (enabled cycles / CLK_DIV) modulo the frame; everything else follows.
    function automatic outs_t model(input longint unsigned en_cycles, input logic en,
                                    input int unsigned cd, input int unsigned hs,
                                    input int unsigned hb, input int unsigned ha,
                                    input int unsigned hf, input int unsigned vs,
                                    input int unsigned vb, input int unsigned va,
                                    input int unsigned vf);
        outs_t       o;
        int unsigned ht, vt, pix, h, v;
        ht    = hs + hb + ha + hf;
        vt    = vs + vb + va + vf;
        pix   = int'((en_cycles / 64'(cd)) % 64'(ht * vt));
        h     = pix % ht;
        v     = pix / ht;
        o.tick = en && ((en_cycles % 64'(cd)) == 64'(cd - 1));
        o.h    = 10'(h);
        o.v    = 10'(v);
        o.hs   = (h >= hs);
        o.vs   = (v >= vs);
        o.onh  = (h >= hs + hb) && (h < hs + hb + ha);
        o.onv  = (v >= vs + vb) && (v < vs + vb + va);
        o.vid  = o.onh && o.onv;
        o.hp   = (h < hs) ? 2'd0 : (h < hs + hb) ? 2'd1 : (h < hs + hb + ha) ? 2'd2 : 2'd3;
        o.vp   = (v < vs) ? 2'd0 : (v < vs + vb) ? 2'd1 : (v < vs + vb + va) ? 2'd2 : 2'd3;
        o.ls   = o.tick && (h == ht - 1);
        o.fs   = o.ls && (v == vt - 1);
        return o;
    endfunction

    task automatic check_out(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (enabled cycles %0d)", name, act, exp, e);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: compare both DUTs to the model, advance through the rising edge.
    task automatic cycle();
        outs_t cd, cs;
        #1;
        cd = model(e, enable, 2, 96, 48, 640, 16, 2, 33, 480, 10);
        cs = model(e, enable, S_CD, S_HS, S_HB, S_HA, S_HF, S_VS, S_VB, S_VA, S_VF);
`ifdef VGA_OUT_REG_EN
        check_out("model_def", act_d, prev_d);
        check_out("model_small", act_s, prev_s);
`else
        check_out("model_def", act_d, cd);
        check_out("model_small", act_s, cs);
`endif
        @(posedge clk);
        prev_d = cd;
        prev_s = cs;
        if (enable) e++;
        @(negedge clk);
    endtask

    vec_t tbl[11];

    initial begin
        logic [26:0] exp_vec, act_vec;
        int first_d, first_s, act_ticks, vs_ticks, fs_cnt, ls_cnt, k;
        bit found;

        // name, enabled cycles, h, v, tick, line_start, hsync, vsync, video_on, h_phase
        tbl[0]  = '{"after_reset",    0,     0,   0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{"hsync_last_low", 191,   95,  0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{"hsync_rise",     192,   96,  0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[3]  = '{"h_143_line0",    286,   143, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[4]  = '{"line_wrap_tick", 1599,  799, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[5]  = '{"line_wrapped",   1600,  0,   1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{"vsync_rise",     3200,  0,   2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[7]  = '{"vid_off_143_35", 56286, 143, 35, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        tbl[8]  = '{"vid_on_144_35",  56288, 144, 35, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
        tbl[9]  = '{"vid_on_783_35",  57566, 783, 35, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
        tbl[10] = '{"vid_off_784_35", 57568, 784, 35, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};

        enable = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_out("reset_state_def", act_d, '0);
        check_out("reset_state_small", act_s, '0);
        @(negedge clk);
        reset = 1'b0;
        e = 0;

        for (int i = 0; i < 11; i++) begin
            while (e < tbl[i].e && errors < 200) begin
                enable = ($urandom_range(0, 19) != 0);
                cycle();
            end
            enable = 1'b1;
`ifdef VGA_OUT_REG_EN
            cycle();
`endif
            #1;
            exp_vec = {10'(tbl[i].h), 10'(tbl[i].v), tbl[i].tick, tbl[i].ls, tbl[i].hs,
                       tbl[i].vs, tbl[i].vid, tbl[i].hp};
            act_vec = {d_h, d_v, d_tick, d_ls, d_hs, d_vs, d_vid, d_hp};
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL %s: got %h expected %h", tbl[i].name, act_vec, exp_vec);
            end
        end

        // Freeze exactly as the counter reaches hCount=500, then resume.
        enable = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            if (((e / 2) % 800) == 500 && (e % 2) == 0) found = 1'b1;
            else cycle();
        end
        check_val("reach_h500", int'(found), 1);
        for (int i = 0; i < 10; i++) begin
            enable = 1'b0;
            #1;
            if (i >= 1) check_val("hold_h_tick", int'({d_h, d_tick, d_ls}), int'({10'd500, 2'b00}));
            cycle();
        end
        enable = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            #1;
            if (d_tick) found = 1'b1;
            cycle();
        end
        check_val("resume_tick_seen", int'(found), 1);
        check_val("resume_h501", int'(d_h), 501);

        // Asynchronous reset in mid-frame, then one full small-raster frame from release.
        #2;
        reset = 1'b1;
        #1;
        check_out("reset_async_def", act_d, '0);
        check_out("reset_async_small", act_s, '0);
        @(negedge clk);
        reset = 1'b0;
        e = 0;
        prev_d = '0;
        prev_s = '0;
        enable = 1'b1;
        first_d = -1;
        first_s = -1;
        act_ticks = 0;
        vs_ticks = 0;
        fs_cnt = 0;
        ls_cnt = 0;
        for (k = 0; k < int'(S_HT * S_VT) + LAT; k++) begin
            #1;
            if (d_tick && first_d < 0) first_d = k;
            if (s_tick && first_s < 0) first_s = k;
            if (s_tick && s_vid) act_ticks++;
            if (s_tick && !s_vs) vs_ticks++;
            if (s_fs) fs_cnt++;
            if (s_ls) ls_cnt++;
            cycle();
        end
        check_val("first_tick_def", first_d, 2 - 1 + LAT);
        check_val("first_tick_small", first_s, int'(S_CD) - 1 + LAT);
        check_val("active_ticks_frame", act_ticks, int'(S_HA * S_VA));
        check_val("vsync_low_ticks", vs_ticks, int'(S_VS * S_HT));
        check_val("frame_start_count", fs_cnt, 1);
        check_val("line_start_count", ls_cnt, int'(S_VT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the VGA raster: generates the pixel-rate tick, horizontal/vertical counters, sync pulses and active-region flags for the 640x480@60 controller.
- Runs from the board clock with an internal divider to pixel rate.
- Feeds counters to the pixel generator and sync/blank to the DAC/pins.
- Each axis is run as a phase state machine (SYNC, BACK, ACTIVE, FRONT).

Parameters:
- CLK_DIV, 2, board clocks per pixel (>=1).
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run/hold control.
- pixel_tick  out  1  one-clk pulse per pixel period.
- hCount  out  10  horizontal position 0..H_TOTAL-1.
- vCount  out  10  vertical line 0..V_TOTAL-1.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- on_h  out  1  hCount inside horizontal active window.
- on_v  out  1  vCount inside vertical active window.
- video_on  out  1  on_h & on_v.
- h_phase  out  2  00 SYNC, 01 BACK, 10 ACTIVE, 11 FRONT.
- v_phase  out  2  same encoding, vertical axis.
- line_start  out  1  pulse on hCount wrap.
- frame_start  out  1  pulse on hCount and vCount wrap.

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP = 800; V_TOTAL = 525. Counter arithmetic is unsigned 10-bit.
- Reset (async, any time, including mid-frame):
  - Divider, hCount and vCount are 0; both phases are SYNC.
  - hsync=0, vsync=0 (count 0 lies in the sync pulse).
  - on_h, on_v, video_on, pixel_tick, line_start and frame_start are 0.
  - After reset release, the first pixel_tick occurs CLK_DIV clocks later.
- Divider:
  - Counts 0..CLK_DIV-1 while enable=1.
  - pixel_tick=1 in the cycle where the divider equals CLK_DIV-1 and enable=1.
  - With CLK_DIV=1, pixel_tick equals enable.
- Horizontal, on pixel_tick:
  - hCount increments; at H_TOTAL-1 it wraps to 0.
  - h_phase advances SYNC->BACK at H_SYNC, BACK->ACTIVE at H_SYNC+H_BP, ACTIVE->FRONT at H_SYNC+H_BP+H_ACTIVE, FRONT->SYNC on wrap.
  - Phase transitions take effect in the same cycle the counter takes the boundary value.
- Vertical:
  - vCount increments only on a pixel_tick where hCount=H_TOTAL-1; it wraps at V_TOTAL-1.
  - v_phase follows the same rules using the V_ parameters.
- Window decode, all combinational from registered state:
  - hsync = !(h_phase==SYNC); vsync = !(v_phase==SYNC).
  - on_h = (h_phase==ACTIVE), i.e. 144<=hCount<784.
  - on_v = (v_phase==ACTIVE), i.e. 35<=vCount<515.
  - video_on = on_h & on_v.
- line_start = pixel_tick & (hCount==H_TOTAL-1).
- frame_start = line_start & (vCount==V_TOTAL-1).
- enable=0:
  - Divider, counters and phases hold; pixel_tick, line_start and frame_start are 0.
  - Decoded outputs keep reflecting the held position.
  - Resuming continues exactly where the controller stopped.
- Phase FSM and counter are checked redundantly: if a phase disagrees with its range, the next pixel_tick forces the phase to match the counter.

Optional Feature:
- Macro: VGA_OUT_REG_EN.
- Defined:
  - hsync, vsync, on_h, on_v, video_on, h_phase, v_phase, hCount and vCount pass through one output register stage.
  - That stage updates every clk, so all outputs are mutually aligned and lag internal state by one clk.
  - Output registers reset to the same values listed under Behaviour.
  - pixel_tick, line_start and frame_start are also delayed one clk to stay aligned.
- Undefined: outputs are as described in Behaviour, zero added latency.

Decomposition:
- Package vga_timing_pkg holds:
  - Phase encoding constants PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT.
  - Default 640x480 timing constants and derived H_TOTAL and V_TOTAL.
- Sub-module vga_axis_seq: one counter plus phase FSM, parameterized by SYNC/BP/ACTIVE/FP.
  - Inputs: step, clear.
  - Outputs: count, phase, wrap.
  - Instantiated twice: horizontal stepped by pixel_tick; vertical stepped by the horizontal wrap.

Test Plan:
- Reset check: assert reset mid-frame at (hCount=300, vCount=200) -> immediately all counts 0, hsync=vsync=0, video_on=0. Release -> first pixel_tick after exactly 2 clks.
- hsync width: hsync low for exactly 96 pixel_ticks (192 clks) from hCount=0. hsync rises when hCount=96, h_phase=BACK.
- Line wrap: at hCount=799 a tick gives hCount=0, vCount+1, line_start=1 for one clk, h_phase=SYNC.
- Frame wrap: at (799,524) a tick gives (0,0) and frame_start=1. vsync low exactly 2 lines (1600 ticks).
- Active window:
  - video_on first 1 at (144,35) and last 1 at (783,514).
  - 0 at (143,35), (784,35) and (144,515).
  - 307200 active ticks per frame.
- Enable and macro:
  - Deassert enable 10 clks at hCount=500 -> counts frozen, no ticks; resume at 501 on the next tick.
  - With VGA_OUT_REG_EN, every output equals the unregistered build's value one clk earlier.
